mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_arb_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and owner IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_IF   = 2'b01,
    ARB_DM   = 2'b10
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, shared memory port, status.
// Handshake: a requester holds req and its command until it sees a one-cycle ack;
// the memory completes the owned access in any cycle it drives mem_ready=1.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;
  arb_state_t        state;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy, state
  );

  // Requesters plus memory.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy, state
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between eligible fetch and data requests.
// Optional feature: ARB_ROUND_ROBIN_EN (conflicts go to the port not served last).
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_elig,
  input  logic dm_elig,
  input  logic last_owner,
  output logic grant_dm
);

`ifdef ARB_ROUND_ROBIN_EN
  assign grant_dm = dm_elig && (!if_elig || (last_owner == OWN_IF));
`else
  // Data port always wins; fetch and history only matter in round-robin builds.
  logic unused_inputs;
  assign unused_inputs = if_elig ^ last_owner;
  assign grant_dm      = dm_elig;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-port memory with variable latency.
// Conflict policy is set in arb_pick by ARB_ROUND_ROBIN_EN (default: data port wins).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  logic              grant, grant_dm;
  logic              if_done, dm_done;
  logic              if_elig, dm_elig;
  logic              if_ack_q, dm_ack_q;
  logic              last_owner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  // A port being acked this cycle still shows req high; it must not be re-granted.
  assign if_elig = bus.if_req & ~if_ack_q;
  assign dm_elig = bus.dm_req & ~dm_ack_q;

  arb_pick u_pick (
    .if_elig    (if_elig),
    .dm_elig    (dm_elig),
    .last_owner (last_owner),
    .grant_dm   (grant_dm)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    if_done = 1'b0;
    dm_done = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (if_elig || dm_elig) begin
          grant   = 1'b1;
          state_d = grant_dm ? ARB_DM : ARB_IF;
        end
      end
      ARB_IF: begin
        if (bus.mem_ready) begin
          if_done = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_DM: begin
        if (bus.mem_ready) begin
          dm_done = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      last_owner <= OWN_IF;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      if_ack_q <= if_done;
      dm_ack_q <= dm_done;
      if (grant) begin
        last_owner <= grant_dm ? OWN_DM : OWN_IF;
        if (grant_dm) begin
          cmd_we    <= bus.dm_we;
          cmd_addr  <= bus.dm_addr;
          cmd_wdata <= bus.dm_wdata;
        end else begin
          cmd_we    <= 1'b0;
          cmd_addr  <= bus.if_addr;
          cmd_wdata <= '0;
        end
      end
      if (if_done) if_rdata_q <= bus.mem_rdata;
      // Store completions leave the last load value visible.
      if (dm_done && !cmd_we) dm_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_req   = (state_q != ARB_IDLE);
  assign bus.busy      = (state_q != ARB_IDLE);
  assign bus.state     = state_q;
  assign bus.mem_we    = cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus short random bench for mem_arbiter with a grant/read-data scoreboard
// and a variable-latency memory responder.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [32:0] exp_grant_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] last_dm = 32'h0;
  logic        exp_last = OWN_IF;

  int   wait_target = 0;
  int   req_cycles = 0;
  int   last_req_cyc = 0;
  int   if_ack_cyc = -1;
  int   dm_ack_cyc = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  // Memory responder and output monitor.
  logic [32:0] held_cmd;
  logic [31:0] held_wdata;
  logic        prev_req = 1'b0;
  int          wcnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req      = 1'b0;
      wcnt          = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
    end else begin
      if (bus.mem_req) begin
        if (!prev_req) begin
          check("grant_expected", 64'(exp_grant_q.size() != 0), 64'd1);
          if (exp_grant_q.size() != 0)
            check("grant_cmd", {bus.mem_we, bus.mem_addr}, exp_grant_q.pop_front());
          held_cmd   = {bus.mem_we, bus.mem_addr};
          held_wdata = bus.mem_wdata;
          wcnt       = 0;
        end else begin
          check("mem_stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {held_cmd, held_wdata});
        end
        bus.mem_ready = (wcnt >= wait_target);
        // Junk on mem_rdata during writes must never reach dm_rdata.
        bus.mem_rdata = bus.mem_we ? $urandom : mem_read(bus.mem_addr);
        if (bus.mem_ready && bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
        wcnt++;
        req_cycles++;
        last_req_cyc = cyc;
      end else begin
        bus.mem_ready = 1'b0;
      end
      prev_req = bus.mem_req;
      check("ack_exclusive", 64'(bus.if_ack & bus.dm_ack), 64'd0);
      if (bus.if_ack) begin
        check("if_ack_expected", 64'(exp_if_q.size() != 0), 64'd1);
        if (exp_if_q.size() != 0) check("if_rdata", bus.if_rdata, exp_if_q.pop_front());
      end
      if (bus.dm_ack) begin
        check("dm_ack_expected", 64'(exp_dm_q.size() != 0), 64'd1);
        if (exp_dm_q.size() != 0) check("dm_rdata", bus.dm_rdata, exp_dm_q.pop_front());
      end
    end
  end

  task automatic push_if(input logic [31:0] a);
    exp_grant_q.push_back({1'b0, a});
    exp_if_q.push_back(exp_read(a));
  endtask

  task automatic push_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
    exp_grant_q.push_back({we, a});
    if (we) exp_mem[a] = d;
    else last_dm = exp_read(a);
    exp_dm_q.push_back(last_dm);
  endtask

  // Drives requests and queues the expected service order.
  task automatic issue(input logic do_if, input logic [31:0] if_a,
                       input logic do_dm, input logic we, input logic [31:0] dm_a,
                       input logic [31:0] d);
    logic dm_first;
    bus.if_req   = do_if;
    bus.if_addr  = if_a;
    bus.dm_req   = do_dm;
    bus.dm_we    = we;
    bus.dm_addr  = dm_a;
    bus.dm_wdata = d;
    if (do_if && do_dm) begin
`ifdef ARB_ROUND_ROBIN_EN
      dm_first = (exp_last == OWN_IF);
`else
      dm_first = 1'b1;
`endif
      if (dm_first) begin
        push_dm(we, dm_a, d);
        push_if(if_a);
        exp_last = OWN_IF;
      end else begin
        push_if(if_a);
        push_dm(we, dm_a, d);
        exp_last = OWN_DM;
      end
    end else if (do_dm) begin
      push_dm(we, dm_a, d);
      exp_last = OWN_DM;
    end else if (do_if) begin
      push_if(if_a);
      exp_last = OWN_IF;
    end
  endtask

  // Holds each request until its ack, then waits for the arbiter to go idle.
  task automatic run_until_idle(input int budget);
    logic drop_if, drop_dm, done;
    done = 1'b0;
    if_ack_cyc = -1;
    dm_ack_cyc = -1;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      drop_if = bus.if_ack;
      drop_dm = bus.dm_ack;
      if (bus.if_ack) if_ack_cyc = cyc;
      if (bus.dm_ack) dm_ack_cyc = cyc;
      @(posedge clk);
      #1;
      if (drop_if) bus.if_req = 1'b0;
      if (drop_dm) bus.dm_req = 1'b0;
      done = !bus.if_req && !bus.dm_req && !bus.busy;
    end
    check("idle_within_budget", 64'(done), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic        r_if, r_dm;
    int          n;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    mem_model[32'h40] = 32'h8C01_0004; exp_mem[32'h40] = 32'h8C01_0004;
    mem_model[32'h20] = 32'h1234_5678; exp_mem[32'h20] = 32'h1234_5678;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", bus.state, ARB_IDLE);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_acks", {bus.if_ack, bus.dm_ack}, 0);
    check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    rst = 1'b0;

    // Lone fetch, minimum latency.
    wait_target = 0;
    @(posedge clk); #1;
    issue(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("lf_c0_mem_req", bus.mem_req, 0);
    @(negedge clk);
    check("lf_c1_mem_req", bus.mem_req, 1);
    check("lf_c1_mem_addr", bus.mem_addr, 32'h40);
    check("lf_c1_mem_we", bus.mem_we, 0);
    check("lf_c1_if_ack", bus.if_ack, 0);
    @(negedge clk);
    check("lf_c2_if_ack", bus.if_ack, 1);
    check("lf_c2_if_rdata", bus.if_rdata, 32'h8C01_0004);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    check("lf_c3_if_ack", bus.if_ack, 0);
    check("lf_c3_busy", bus.busy, 0);

    // Conflict: data write wins, fetch of the same address sees the stored word.
    @(posedge clk); #1;
    issue(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    run_until_idle(20);
    check("cf_gap", 64'((if_ack_cyc - dm_ack_cyc) >= 2 && dm_ack_cyc >= 0), 64'd1);
    check("cf_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    check("cf_dm_rdata_kept", bus.dm_rdata, 32'h0);

    // Three back-to-back conflicting pairs with random wait states.
    for (int p = 0; p < 3; p++) begin
      wait_target = $urandom_range(0, 2);
      @(posedge clk); #1;
      issue(1'b1, 32'h40, 1'b1, 1'b0, 32'h10 * (p + 1), 32'h0);
      run_until_idle(30);
    end

    // Wait states: three low cycles before mem_ready.
    wait_target = 3;
    @(posedge clk); #1;
    req_cycles = 0;
    issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    run_until_idle(30);
    check("ws_req_cycles", req_cycles, 4);
    check("ws_ack_latency", dm_ack_cyc, last_req_cyc + 1);
    check("ws_dm_rdata", bus.dm_rdata, 32'h1234_5678);
    check("ws_busy_after", bus.busy, 0);

    // Store keeps the previous load value; reload returns the stored word.
    wait_target = 1;
    @(posedge clk); #1;
    issue(1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D);
    run_until_idle(20);
    check("wr_dm_rdata_kept", bus.dm_rdata, 32'h1234_5678);
    @(posedge clk); #1;
    issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
    run_until_idle(20);
    check("rd_after_wr", bus.dm_rdata, 32'hCAFE_F00D);

    // Reset in the middle of a data read.
    wait_target = 10;
    @(posedge clk); #1;
    issue(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    n = 0;
    while (!bus.mem_req && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_in_dm", bus.state, ARB_DM);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.dm_req = 1'b0;
    void'(exp_dm_q.pop_back());
    last_dm  = 32'h0;
    exp_last = OWN_IF;
    #1;
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_state", bus.state, ARB_IDLE);
    check("rst_mid_cmd", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    check("rst_mid_acks", {bus.if_ack, bus.dm_ack}, 0);
    check("rst_mid_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_target = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_dm_ack", bus.dm_ack, 0);
      check("rst_idle", bus.busy, 0);
    end
    @(posedge clk); #1;
    issue(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    run_until_idle(20);
    check("post_rst_fetch", bus.if_rdata, 32'h8C01_0004);

    // Random mix of single and conflicting requests.
    for (int t = 0; t < 10; t++) begin
      r_if = 1'($urandom_range(0, 1));
      r_dm = r_if ? 1'($urandom_range(0, 1)) : 1'b1;
      ra   = 32'h10 * $urandom_range(1, 5);
      wait_target = $urandom_range(0, 3);
      @(posedge clk); #1;
      issue(r_if, 32'h10 * $urandom_range(1, 5), r_dm, 1'($urandom_range(0, 1)), ra, $urandom);
      run_until_idle(40);
    end

    repeat (2) @(posedge clk);
    check("grant_q_drained", exp_grant_q.size(), 0);
    check("if_q_drained", exp_if_q.size(), 0);
    check("dm_q_drained", exp_dm_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
